// File: rtl/mccoy_pkg.sv
// Shared constants, state encoding and sizing helper for the McCoy program sequencer.
package mccoy_pkg;

    localparam int INSTR_W = 6;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mccoy_prog_sequencer_if.sv
// Program load handshake between the host and the sequencer.
interface mccoy_prog_sequencer_if #(
    parameter int INSTR_W = mccoy_pkg::INSTR_W
) ();
    logic               load_valid;
    logic [INSTR_W-1:0] load_instr;
    logic               load_ready;

    modport master (output load_valid, load_instr, input load_ready);
    modport slave  (input load_valid, load_instr, output load_ready);
endinterface

// File: rtl/mccoy_prog_mem.sv
// Program register file: one synchronous write port, one asynchronous read port, contents not reset.
module mccoy_prog_mem #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = mccoy_pkg::INSTR_W,
    localparam int AW     = mccoy_pkg::ptr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mccoy_prog_sequencer.sv
// Program sequencer feeding the McCoy core: load, replay with hold/stop, NOP when idle.
// Define MCCOY_PROG_LOOP_EN to honour the loop input (continuous replay until stop).
module mccoy_prog_sequencer #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = mccoy_pkg::INSTR_W,
    localparam int AW     = mccoy_pkg::ptr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mccoy_prog_sequencer_if.slave  ld,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   hold,
    input  logic                   loop,
    output logic [INSTR_W-1:0]     instr_out,
    output logic                   instr_valid,
    output logic [AW-1:0]          pc_out,
    output logic [AW:0]            count,
    output logic                   busy,
    output logic                   done
);
    import mccoy_pkg::*;

    localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR);
    localparam logic [AW:0]        DEPTH_C = (AW+1)'(DEPTH);

    state_e             state_q, state_d;
    logic [AW:0]        ptr_q, ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               ivld_q, ivld_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               we;
    logic               loop_act;
    logic               wrap;
    logic [INSTR_W-1:0] rdata;

`ifdef MCCOY_PROG_LOOP_EN
    assign loop_act = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_act    = 1'b0;
`endif

    mccoy_prog_mem #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[AW-1:0]),
        .wdata (ld.load_instr),
        .raddr (ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign ld.load_ready = (state_q == ST_IDLE) && (count_q < DEPTH_C);
    assign wrap          = loop_act && (ptr_q == count_q - 1'b1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        instr_d = NOP;
        ivld_d  = 1'b0;
        pc_d    = pc_q;
        done_d  = 1'b0;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else begin
                    if (ld.load_valid && ld.load_ready) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    ptr_d = ptr_q;
                end else if (ptr_q == count_q) begin
                    // Pointer ran past the last word: this is the drain cycle into DONE.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    instr_d = rdata;
                    ivld_d  = 1'b1;
                    pc_d    = ptr_q[AW-1:0];
                    ptr_d   = wrap ? '0 : ptr_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            instr_q <= NOP;
            ivld_q  <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            instr_q <= instr_d;
            ivld_q  <= ivld_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = ivld_q;
    assign pc_out      = pc_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_mccoy_prog_sequencer.sv
// Directed bench for mccoy_prog_sequencer: load/run, full buffer, hold, stop, clear, loop, async reset.
module tb_mccoy_prog_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, loop = 1'b0;
    logic [5:0] instr_out;
    logic       instr_valid;
    logic [3:0] pc_out;
    logic [4:0] count;
    logic       busy, done;
    int         n_cmp = 0;
    int         n_err = 0;

    mccoy_prog_sequencer_if #(.INSTR_W(6)) ld ();

    mccoy_prog_sequencer #(.DEPTH(16), .INSTR_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ld          (ld),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .loop        (loop),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [5:0] w);
        ld.load_valid = 1'b1;
        ld.load_instr = w;
        tick();
        ld.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (instr_out !== 6'h00) begin n_err++; $display("FAIL reset_instr got %h exp 00", instr_out); end
        n_cmp++; if ({instr_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {instr_valid, busy, done}); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (pc_out !== 4'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", pc_out); end
    endtask

    task automatic test_load_and_run();
        load_word(6'h01); load_word(6'h2A); load_word(6'h3F);
        n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL lr_count got %0d exp 3", count); end
        start = 1'b1; tick(); start = 1'b0;   // edge N
        n_cmp++; if ({busy, instr_valid} !== 2'b10) begin n_err++; $display("FAIL lr_n got %b exp 10", {busy, instr_valid}); end
        tick();
        n_cmp++; if ({instr_valid, instr_out, pc_out} !== {1'b1, 6'h01, 4'd0}) begin n_err++; $display("FAIL lr_w0 got %b/%h/%0d exp 1/01/0", instr_valid, instr_out, pc_out); end
        tick();
        n_cmp++; if ({instr_valid, instr_out, pc_out} !== {1'b1, 6'h2A, 4'd1}) begin n_err++; $display("FAIL lr_w1 got %b/%h/%0d exp 1/2a/1", instr_valid, instr_out, pc_out); end
        tick();
        n_cmp++; if ({instr_valid, instr_out, pc_out, done} !== {1'b1, 6'h3F, 4'd2, 1'b0}) begin n_err++; $display("FAIL lr_w2 got %b/%h/%0d/%b exp 1/3f/2/0", instr_valid, instr_out, pc_out, done); end
        tick();   // N+4
        n_cmp++; if ({done, instr_valid, instr_out, ld.load_ready} !== {1'b1, 1'b0, 6'h00, 1'b0}) begin n_err++; $display("FAIL lr_done got %b/%b/%h/%b exp 1/0/00/0", done, instr_valid, instr_out, ld.load_ready); end
        tick();
        n_cmp++; if ({done, busy, ld.load_ready, count} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin n_err++; $display("FAIL lr_idle got %b/%b/%b/%0d exp 0/0/1/3", done, busy, ld.load_ready, count); end
    endtask

    task automatic test_full();
        do_clear();
        ld.load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld.load_instr = 6'(i + 1);
            tick();
        end
        n_cmp++; if ({count, ld.load_ready} !== {5'd16, 1'b0}) begin n_err++; $display("FAIL full_cnt got %0d/%b exp 16/0", count, ld.load_ready); end
        ld.load_instr = 6'h3E;
        tick();
        ld.load_valid = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_17th got %0d exp 16", count); end
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (instr_out !== 6'(i + 1)) begin n_err++; $display("FAIL full_word%0d got %h exp %h", i, instr_out, 6'(i + 1)); end
        end
        tick();
        n_cmp++; if ({done, instr_valid} !== 2'b10) begin n_err++; $display("FAIL full_done got %b exp 10", {done, instr_valid}); end
        tick();
    endtask

    task automatic test_hold();
        do_clear();
        load_word(6'h05); load_word(6'h06);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++; if ({instr_valid, instr_out} !== {1'b1, 6'h05}) begin n_err++; $display("FAIL hold_w0 got %b/%h exp 1/05", instr_valid, instr_out); end
        hold = 1'b1;
        tick();
        n_cmp++; if ({instr_valid, instr_out, busy} !== {1'b0, 6'h00, 1'b1}) begin n_err++; $display("FAIL hold_nop1 got %b/%h/%b exp 0/00/1", instr_valid, instr_out, busy); end
        tick();
        n_cmp++; if ({instr_valid, instr_out} !== {1'b0, 6'h00}) begin n_err++; $display("FAIL hold_nop2 got %b/%h exp 0/00", instr_valid, instr_out); end
        hold = 1'b0;
        tick();
        n_cmp++; if ({instr_valid, instr_out, pc_out} !== {1'b1, 6'h06, 4'd1}) begin n_err++; $display("FAIL hold_w1 got %b/%h/%0d exp 1/06/1", instr_valid, instr_out, pc_out); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL hold_done got %b exp 1", done); end
        tick();
    endtask

    task automatic test_stop();
        do_clear();
        load_word(6'h0A); load_word(6'h0B); load_word(6'h0C); load_word(6'h0D);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++; if (instr_out !== 6'h0A) begin n_err++; $display("FAIL stop_w0 got %h exp 0a", instr_out); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if ({instr_valid, instr_out, busy, done} !== {1'b0, 6'h00, 1'b0, 1'b0}) begin n_err++; $display("FAIL stop_nop got %b/%h/%b/%b exp 0/00/0/0", instr_valid, instr_out, busy, done); end
        tick();
        n_cmp++; if ({done, busy, ld.load_ready} !== 3'b001) begin n_err++; $display("FAIL stop_idle got %b exp 001", {done, busy, ld.load_ready}); end
    endtask

    task automatic test_start_empty();
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if ({busy, count} !== {1'b0, 5'd0}) begin n_err++; $display("FAIL empty_start got %b/%0d exp 0/0", busy, count); end
        tick();
        n_cmp++; if ({busy, instr_valid, done} !== 3'b000) begin n_err++; $display("FAIL empty_idle got %b exp 000", {busy, instr_valid, done}); end
    endtask

    task automatic test_clear_load();
        load_word(6'h15);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL cl_pre got %0d exp 1", count); end
        clear = 1'b1; start = 1'b1;
        ld.load_valid = 1'b1; ld.load_instr = 6'h16;
        tick();
        clear = 1'b0; start = 1'b0; ld.load_valid = 1'b0;
        n_cmp++; if ({count, busy} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL cl_both got %0d/%b exp 0/0", count, busy); end
    endtask

    task automatic test_loop();
        do_clear();
        load_word(6'h11); load_word(6'h22);
        loop = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
`ifdef MCCOY_PROG_LOOP_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({instr_valid, instr_out, pc_out, done} !== {1'b1, (i[0] ? 6'h22 : 6'h11), 4'(i % 2), 1'b0}) begin
                n_err++; $display("FAIL loop_w%0d got %b/%h/%0d/%b", i, instr_valid, instr_out, pc_out, done);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if ({busy, instr_valid, done} !== 3'b000) begin n_err++; $display("FAIL loop_stop got %b exp 000", {busy, instr_valid, done}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL loop_nodone got %b exp 0", done); end
`else
        tick(); tick();
        n_cmp++; if ({instr_valid, instr_out} !== {1'b1, 6'h22}) begin n_err++; $display("FAIL noloop_w1 got %b/%h exp 1/22", instr_valid, instr_out); end
        tick();
        n_cmp++; if ({done, instr_valid} !== 2'b10) begin n_err++; $display("FAIL noloop_done got %b exp 10", {done, instr_valid}); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noloop_idle got %b exp 0", busy); end
`endif
        loop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        load_word(6'h21); load_word(6'h22); load_word(6'h23);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++; if ({busy, instr_out} !== {1'b1, 6'h21}) begin n_err++; $display("FAIL rst_pre got %b/%h exp 1/21", busy, instr_out); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({instr_out, busy, count, instr_valid} !== {6'h00, 1'b0, 5'd0, 1'b0}) begin n_err++; $display("FAIL rst_async got %h/%b/%0d/%b exp 00/0/0/0", instr_out, busy, count, instr_valid); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if ({ld.load_ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL rst_after got %b exp 100", {ld.load_ready, busy, done}); end
    endtask

    initial begin
        ld.load_valid = 1'b0;
        ld.load_instr = '0;
        #12;
        test_reset();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (ld.load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ld.load_ready); end
        test_load_and_run();
        test_full();
        test_hold();
        test_stop();
        test_start_empty();
        test_clear_load();
        test_loop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
